// File: rtl/quad_encoder_gen.sv
// Quadrature encoder emulator: signed step command -> Gray-coded {B,A} edges every P clk, with running position.
// Latency: k-th transition at accept edge + k*P; cmd_ready only in IDLE with abort low, so commands wait while busy.
module quad_encoder_gen #(
    parameter int COUNT_WIDTH  = 16,
    parameter int PERIOD_WIDTH = 16,
    parameter int MIN_PERIOD   = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [COUNT_WIDTH-1:0]  cmd_steps,
    input  logic [PERIOD_WIDTH-1:0] cmd_period,
    input  logic                    abort,
    output logic [1:0]              enc,
    output logic                    busy,
    output logic                    done,
    output logic [COUNT_WIDTH-1:0]  position
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                  state_q, state_d;
    logic [1:0]              enc_q, enc_d;
    logic [COUNT_WIDTH-1:0]  pos_q, pos_d;
    logic [COUNT_WIDTH-1:0]  rem_q, rem_d;
    logic                    rev_q, rev_d;
    logic [PERIOD_WIDTH-1:0] per_q, per_d;
    logic [PERIOD_WIDTH-1:0] timer_q, timer_d;
    logic                    done_q, done_d;

    logic                    accept;
    logic [PERIOD_WIDTH-1:0] per_clamped;
    logic [COUNT_WIDTH-1:0]  steps_mag;
    logic [1:0]              enc_next;

    assign per_clamped = (cmd_period < PERIOD_WIDTH'(MIN_PERIOD)) ? PERIOD_WIDTH'(MIN_PERIOD) : cmd_period;
    // Unsigned magnitude: the most negative value maps to 2^(W-1) without overflow.
    assign steps_mag   = cmd_steps[COUNT_WIDTH-1] ? (~cmd_steps + COUNT_WIDTH'(1)) : cmd_steps;

    assign cmd_ready = rst_n && (state_q == IDLE) && !abort;
    assign accept    = cmd_valid && cmd_ready;

    always_comb begin
        enc_next = enc_q;
        case ({rev_q, enc_q})
            3'b0_00: enc_next = 2'b01;
            3'b0_01: enc_next = 2'b11;
            3'b0_11: enc_next = 2'b10;
            3'b0_10: enc_next = 2'b00;
            3'b1_00: enc_next = 2'b10;
            3'b1_10: enc_next = 2'b11;
            3'b1_11: enc_next = 2'b01;
            3'b1_01: enc_next = 2'b00;
            default: enc_next = enc_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        enc_d   = enc_q;
        pos_d   = pos_q;
        rem_d   = rem_q;
        rev_d   = rev_q;
        per_d   = per_q;
        timer_d = timer_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (cmd_steps == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = RUN;
                        per_d   = per_clamped;
                        timer_d = per_clamped - PERIOD_WIDTH'(1);
                        rev_d   = cmd_steps[COUNT_WIDTH-1];
                        rem_d   = steps_mag;
                    end
                end
            end
            RUN: begin
                // Abort wins over a transition due on the same edge.
                if (abort) begin
                    state_d = IDLE;
                end else if (timer_q == '0) begin
                    enc_d   = enc_next;
                    pos_d   = rev_q ? (pos_q - COUNT_WIDTH'(1)) : (pos_q + COUNT_WIDTH'(1));
                    rem_d   = rem_q - COUNT_WIDTH'(1);
                    timer_d = per_q - PERIOD_WIDTH'(1);
                    if (rem_q == COUNT_WIDTH'(1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    timer_d = timer_q - PERIOD_WIDTH'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            enc_q   <= 2'b00;
            pos_q   <= '0;
            rem_q   <= '0;
            rev_q   <= 1'b0;
            per_q   <= '0;
            timer_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            enc_q   <= enc_d;
            pos_q   <= pos_d;
            rem_q   <= rem_d;
            rev_q   <= rev_d;
            per_q   <= per_d;
            timer_q <= timer_d;
            done_q  <= done_d;
        end
    end

    assign enc      = enc_q;
    assign busy     = (state_q == RUN);
    assign done     = done_q;
    assign position = pos_q;

endmodule

// File: tb/tb_quad_encoder_gen.sv
// Bench for quad_encoder_gen: directed scenarios then random commands against a schedule-based reference model.
module tb_quad_encoder_gen;

    localparam int CW = 16;
    localparam int PW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [CW-1:0] cmd_steps = '0;
    logic [PW-1:0] cmd_period = '0;
    logic          abort = 1'b0;
    logic [1:0]    enc;
    logic          busy;
    logic          done;
    logic [CW-1:0] position;

    quad_encoder_gen #(.COUNT_WIDTH(CW), .PERIOD_WIDTH(PW), .MIN_PERIOD(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_steps  (cmd_steps),
        .cmd_period (cmd_period),
        .abort      (abort),
        .enc        (enc),
        .busy       (busy),
        .done       (done),
        .position   (position)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: position is an integer; enc is the Gray code of position mod 4,
    // since both start at zero and move together one step per transition.
    bit     m_busy, m_done;
    int     m_pos, m_rem, m_dir, m_per;
    longint cyc, m_next;
    logic [1:0] prev_enc;

    function automatic logic [1:0] gray_of(input int p);
        case (p & 3)
            0:       return 2'b00;
            1:       return 2'b01;
            2:       return 2'b11;
            default: return 2'b10;
        endcase
    endfunction

    function automatic logic [31:0] pos16(input int p);
        logic [31:0] t;
        t = p;
        return {16'h0, t[15:0]};
    endfunction

    // Called at a negedge: drive inputs, check outputs, advance the model over the coming posedge.
    task automatic step(input bit v, input int steps, input int per, input bit ab);
        logic [31:0] s;
        s          = steps;
        cmd_valid  = v;
        cmd_steps  = s[CW-1:0];
        cmd_period = PW'(per);
        abort      = ab;
        #1;
        check_val("enc",       {30'h0, enc},   {30'h0, gray_of(m_pos)});
        check_val("position",  {16'h0, position}, pos16(m_pos));
        check_val("busy",      {31'h0, busy},  {31'h0, m_busy});
        check_val("done",      {31'h0, done},  {31'h0, m_done});
        check_val("cmd_ready", {31'h0, cmd_ready}, {31'h0, (!m_busy && !ab)});
        check_val("one_bit_change", {31'h0, ($countones(enc ^ prev_enc) <= 1)}, 32'h1);
        prev_enc = enc;

        cyc++;
        m_done = 1'b0;
        if (m_busy) begin
            if (ab) begin
                m_busy = 1'b0;
            end else if (cyc == m_next) begin
                m_pos  += m_dir;
                m_rem--;
                m_next += m_per;
                if (m_rem == 0) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                end
            end
        end else if (v && !ab) begin
            if (steps == 0) begin
                m_done = 1'b1;
            end else begin
                m_busy = 1'b1;
                m_dir  = (steps > 0) ? 1 : -1;
                m_rem  = (steps > 0) ? steps : -steps;
                m_per  = (per < 2) ? 2 : per;
                m_next = cyc + m_per;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 0, 1'b0);
    endtask

    // Async reset asserted mid-cycle; outputs must clear before any clock edge.
    task automatic do_reset();
        cmd_valid = 1'b1;
        abort     = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_val("rst_enc",       {30'h0, enc},       32'h0);
        check_val("rst_position",  {16'h0, position},  32'h0);
        check_val("rst_busy",      {31'h0, busy},      32'h0);
        check_val("rst_done",      {31'h0, done},      32'h0);
        check_val("rst_cmd_ready", {31'h0, cmd_ready}, 32'h0);
        cmd_valid = 1'b0;
        @(negedge clk);
        rst_n    = 1'b1;
        m_busy   = 1'b0;
        m_done   = 1'b0;
        m_pos    = 0;
        prev_enc = 2'b00;
    endtask

    initial begin
        cyc = 0;
        @(negedge clk);
        do_reset();
        idle(2);

        // +5 steps at P=4
        step(1'b1, 5, 4, 1'b0);
        idle(24);
        check_val("fwd5_position", {16'h0, position}, 32'h5);
        check_val("fwd5_enc",      {30'h0, enc},      32'h1);

        // -3 steps, period clamped from 1 to 2
        step(1'b1, -3, 1, 1'b0);
        idle(8);
        check_val("rev3_position", {16'h0, position}, 32'h2);
        check_val("rev3_enc",      {30'h0, enc},      32'h3);
        step(1'b1, -2, 2, 1'b0);
        idle(6);
        step(1'b1, -1, 3, 1'b0);
        idle(5);
        check_val("wrap_position", {16'h0, position}, 32'hFFFF);

        // zero-step command
        step(1'b1, 0, 5, 1'b0);
        idle(3);

        // abort at T+7 of a +10/P=3 command; held-off command under abort, then accept at T+8
        step(1'b1, 10, 3, 1'b0);
        idle(6);
        step(1'b1, 7, 2, 1'b1);
        check_val("abort_position", {16'h0, position}, 32'h1);
        step(1'b1, 1, 2, 1'b0);
        idle(4);
        check_val("after_abort_position", {16'h0, position}, 32'h2);

        // back-to-back: second command presented continuously, accepted in the done cycle
        step(1'b1, 3, 2, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b1, 2, 2, 1'b0);
        idle(6);
        check_val("b2b_position", {16'h0, position}, 32'h7);

        // most negative step count runs in reverse; aborted after a few transitions
        step(1'b1, -32768, 2, 1'b0);
        idle(9);
        step(1'b0, 0, 0, 1'b1);
        idle(2);

        // reset in the middle of a run
        step(1'b1, 4, 3, 1'b0);
        idle(4);
        do_reset();
        idle(2);

        for (int i = 0; i < 2500; i++) begin
            step(($urandom_range(0, 3) == 0),
                 int'($urandom_range(0, 12)) - 6,
                 int'($urandom_range(0, 5)),
                 ($urandom_range(0, 30) == 0));
        end
        idle(40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
